// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan controller.
//   state_e   : controller FSM states
//   SEL_W_DEF : default select width, N_DEF channels derived from it
//   CNT_W     : settle-counter width (covers SETTLE up to 255)
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int SEL_W_DEF = 3;
  localparam int N_DEF     = 2 ** SEL_W_DEF;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// mux_scan_settle_cnt: settle interval counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count up by one
//   tc         : terminal count, high while count == SETTLE-1
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the select of an N:1 mux, waits SETTLE cycles per
// channel, samples the mux output, and publishes an N-bit snapshot.
//   clk, rst_n  : clock, async active-low reset
//   start       : scan request, only honoured in IDLE
//   mux_y       : downstream mux output
//   mux_sel     : registered select into the mux
//   busy        : scan in progress (until DONE completes)
//   done        : one-cycle pulse when data is published
//   data        : last completed snapshot
//   data_valid  : snapshot valid, cleared on start acceptance
//   scan_mask   : (MUX_SCAN_MASK_EN only) channels to skip, captured at start
// Build option: define MUX_SCAN_MASK_EN to add the scan_mask port.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter  int SEL_W  = SEL_W_DEF,
  parameter  int SETTLE = 2,
  localparam int N      = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mux_y,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]     scan_mask,
`endif
  output logic [SEL_W-1:0] mux_sel,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     data,
  output logic             data_valid
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dv_q, dv_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     data_q, data_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [N-1:0]     skip_start, skip_run;
  logic [SEL_W:0]   nxt_start, nxt_run;

`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  assign skip_start = scan_mask;
  assign skip_run   = mask_q;
`else
  assign skip_start = '0;
  assign skip_run   = '0;
`endif

  // Lowest non-skipped channel at index >= lo; MSB flags "found".
  function automatic logic [SEL_W:0] next_ch(input logic [N-1:0] skip, input int lo);
    logic [SEL_W:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--)
      if (k >= lo && !skip[k]) r = {1'b1, SEL_W'(k)};
    return r;
  endfunction

  assign nxt_start = next_ch(skip_start, 0);
  assign nxt_run   = next_ch(skip_run, int'(sel_q) + 1);

  mux_scan_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dv_d     = dv_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = '0;
          dv_d     = 1'b0;
          busy_d   = 1'b1;
          cnt_clr  = 1'b1;
`ifdef MUX_SCAN_MASK_EN
          mask_d   = scan_mask;
`endif
          if (nxt_start[SEL_W]) begin
            sel_d   = nxt_start[SEL_W-1:0];
            state_d = ST_SETTLE;
          end else begin
            sel_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        shadow_d[sel_q] = mux_y;
        if (nxt_run[SEL_W]) begin
          sel_d   = nxt_run[SEL_W-1:0];
          cnt_clr = 1'b1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Publication happens on the edge leaving DONE, so done/data appear
        // together one cycle after the last sample.
        data_d  = shadow_q;
        dv_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dv_q     <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
`ifdef MUX_SCAN_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dv_q     <= dv_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
`ifdef MUX_SCAN_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign mux_sel    = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign data       = data_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl with a behavioural
// 8:1 mux on its select. Expected snapshots and done cycles are queued at
// start and popped when done pulses.
module tb_mux_scan_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] i_vec = '0;
  logic         mux_y;
  logic [2:0]   mux_sel;
  logic         busy, done, dv;
  logic [N-1:0] data;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0] scan_mask = '0;
`endif

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       sel_chk = 1'b0;
  int         sel_acc = 0;
  logic [7:0] last_data = '0;
  int         acc;
  int         bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_y = i_vec[mux_sel];

  mux_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mux_y      (mux_y),
`ifdef MUX_SCAN_MASK_EN
    .scan_mask  (scan_mask),
`endif
    .mux_sel    (mux_sel),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .data_valid (dv)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Done monitor and select-walk checker.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("done_cyc", 32'(cyc), 32'(mon_e.due));
        chk("data", 32'(data), 32'(mon_e.d));
        chk("data_valid", 32'(dv), 32'd1);
        last_data = mon_e.d;
      end
    end
    if (sel_chk && cyc >= sel_acc && cyc < sel_acc + 24)
      chk("mux_sel", 32'(mux_sel), 32'((cyc - sel_acc) / 3));
  end

  // Called at a negedge while idle; the next posedge accepts.
  task automatic start_scan(input logic [7:0] exp, input int lat, input bit push, output int a);
    start = 1'b1;
    a = cyc + 1;
    if (push) q.push_back('{exp, a + lat});
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("dv_cleared", 32'(dv), 32'd0);
    chk("data_stable", 32'(data), 32'(last_data));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},  32'(mux_sel), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_dv"},   32'(dv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, then idle with start low.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mux_sel !== 3'd0 || busy !== 1'b0) bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);

    // Full scan, select walk checked every cycle.
    i_vec   = 8'hA6;
    sel_acc = cyc + 1;
    sel_chk = 1'b1;
    start_scan(8'hA6, 25, 1, acc);
    drain("scan_a6");
    sel_chk = 1'b0;
    @(negedge clk);
    chk("dv_after", 32'(dv), 32'd1);
    chk("data_after", 32'(data), 32'hA6);
    chk("busy_after", 32'(busy), 32'd0);

    // Start pulse in the middle of a scan is ignored.
    i_vec = 8'h5A;
    start_scan(8'h5A, 25, 1, acc);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("scan_ignored_start");
    repeat (30) @(negedge clk);
    chk("idle_after_ignored", 32'(busy), 32'd0);

    // Asynchronous reset mid-scan discards the scan.
    i_vec = 8'h3C;
    start_scan(8'h3C, 25, 0, acc);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    last_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    i_vec = 8'hFF;
    start_scan(8'hFF, 25, 1, acc);
    drain("scan_ff");

    // Back-to-back scans with start held high.
    i_vec = 8'h0F;
    start = 1'b1;
    acc   = cyc + 1;
    q.push_back('{8'h0F, acc + 25});
    q.push_back('{8'hF0, acc + 51});
    while (cyc < acc + 25) @(negedge clk);
    i_vec = 8'hF0;
    while (cyc < acc + 51) @(negedge clk);
    start = 1'b0;
    drain("back_to_back");

`ifdef MUX_SCAN_MASK_EN
    scan_mask = 8'b1111_0101;
    i_vec     = 8'hFF;
    start_scan(8'h0A, 7, 1, acc);
    drain("mask_f5");
    scan_mask = 8'hFF;
    start_scan(8'h00, 1, 1, acc);
    drain("mask_ff");
    scan_mask = 8'h00;
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
